temp_req_sched: RTL and testbench



---
 rtl/temp_sched_pkg.sv | 30 +++
 rtl/temp_req_sched_rr_pick3.sv | 26 ++
 rtl/temp_req_sched.sv | 170 +++++++++++++++++
 tb/tb_temp_req_sched.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_sched_pkg.sv
// temp_sched_pkg
//   Shared definitions for the temperature request scheduler: scheduler
//   state encoding, requester count, default timing constants and a small
//   index-wrap helper used by the round-robin picker and the pointer update.
//   No ports (package).
package temp_sched_pkg;

  localparam int NUM_REQ         = 3;
  localparam int IDX_W           = 2;
  localparam int DATA_W          = 8;
  localparam int TIMEOUT_CYC_DEF = 100_000_000;  // 2 s at 50 MHz
  localparam int CACHE_CYC_DEF   = 25_000_000;   // 0.5 s at 50 MHz

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  // (base + ofs) mod NUM_REQ, for base < NUM_REQ and 0 <= ofs < NUM_REQ.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int               ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

endpackage

// File: rtl/temp_req_sched_rr_pick3.sv
// rr_pick3
//   Combinational round-robin picker for three requesters. The winner is
//   the first asserted request at or after rr_ptr, wrapping 2 -> 0.
//   Ports:
//     req     in  [NUM_REQ-1:0]  request levels
//     rr_ptr  in  [IDX_W-1:0]    highest-priority index for this pick
//     gnt_idx out [IDX_W-1:0]    winning index (rr_ptr when nothing asserted)
//     any     out                at least one request asserted
module rr_pick3 import temp_sched_pkg::*; (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  always_comb begin
    gnt_idx = rr_ptr;
    any     = |req;
    // Walk offsets from farthest to nearest so the nearest asserted
    // requester, counting from rr_ptr, is the assignment left standing.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[wrap_idx(rr_ptr, k)]) gnt_idx = wrap_idx(rr_ptr, k);
    end
  end

endmodule

// File: rtl/temp_req_sched.sv
// temp_req_sched
//   Arbitrates three requesters for one shared 1-Wire temperature engine.
//   A granted request either starts an engine convert+read and waits for
//   the result (bounded by TIMEOUT_CYC), or, when the optional reading
//   cache is built in and fresh, is answered directly from the cache.
//   Every answer is a one-cycle one-hot ack with rsp_* valid alongside.
//
//   Build option: define TEMP_SCHED_CACHE_EN to include the reading cache
//   (last good reading plus saturating age counter, hit while the age is
//   below CACHE_CYC). Without it every grant goes to the engine.
//
//   Ports:
//     sys_clk    in         system clock (50 MHz)
//     sys_rst    in         synchronous active-high reset
//     req        in  [2:0]  level requests, held until acked
//     ack        out [2:0]  one-hot one-cycle answer pulse
//     rsp_int    out [7:0]  temperature integer part
//     rsp_deci   out [7:0]  temperature tenths
//     rsp_err    out        sensor timeout (data forced to 0)
//     eng_start  out        one-cycle engine start pulse
//     eng_done   in         one-cycle engine completion pulse
//     eng_int    in  [7:0]  engine result integer part
//     eng_deci   in  [7:0]  engine result tenths
//     busy       out        scheduler not idle
module temp_req_sched #(
  parameter int NUM_REQ     = temp_sched_pkg::NUM_REQ,
  parameter int TIMEOUT_CYC = temp_sched_pkg::TIMEOUT_CYC_DEF,
  parameter int CACHE_CYC   = temp_sched_pkg::CACHE_CYC_DEF
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic [NUM_REQ-1:0]                req,
  output logic [NUM_REQ-1:0]                ack,
  output logic [temp_sched_pkg::DATA_W-1:0] rsp_int,
  output logic [temp_sched_pkg::DATA_W-1:0] rsp_deci,
  output logic                              rsp_err,
  output logic                              eng_start,
  input  logic                              eng_done,
  input  logic [temp_sched_pkg::DATA_W-1:0] eng_int,
  input  logic [temp_sched_pkg::DATA_W-1:0] eng_deci,
  output logic                              busy
);

  import temp_sched_pkg::*;

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  sched_state_e     state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             cache_hit;

  rr_pick3 u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

`ifdef TEMP_SCHED_CACHE_EN
  localparam int AGE_W = $clog2(CACHE_CYC + 1);

  logic              cache_vld;
  logic [AGE_W-1:0]  cache_age;
  logic [DATA_W-1:0] cache_int;
  logic [DATA_W-1:0] cache_deci;

  // Age stops at CACHE_CYC; anything at or beyond the window is equally stale.
  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_W'(CACHE_CYC)) ? a : a + 1'b1;
  endfunction

  assign cache_hit = cache_vld && (cache_age < AGE_W'(CACHE_CYC));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cache_vld <= 1'b0;
      cache_age <= '0;
    end else if (state == ST_WAIT && eng_done) begin
      cache_vld <= 1'b1;
      cache_age <= '0;
    end else begin
      if (state == ST_WAIT && timeout_hit) cache_vld <= 1'b0;
      cache_age <= age_sat_inc(cache_age);
    end
  end

  // Cached reading itself is qualified by cache_vld and needs no reset.
  always_ff @(posedge sys_clk) begin
    if (state == ST_WAIT && eng_done) begin
      cache_int  <= eng_int;
      cache_deci <= eng_deci;
    end
  end
`else
  // No cache: never a hit (the comparison is constant 0 for any legal window).
  assign cache_hit = (CACHE_CYC < 0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_any) state_nxt = cache_hit ? ST_RESP : ST_START;
      ST_START: state_nxt = ST_WAIT;
      // eng_done and timeout land on the same transition; data selection
      // below gives eng_done priority.
      ST_WAIT:  if (eng_done || timeout_hit) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ack          = '0;
    eng_start    = (state == ST_START);
    busy         = (state != ST_IDLE);
    if (state == ST_RESP) ack[gnt_idx] = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      wait_cnt <= '0;
      rsp_int  <= '0;
      rsp_deci <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_idx <= pick_idx;
`ifdef TEMP_SCHED_CACHE_EN
            if (cache_hit) begin
              rsp_int  <= cache_int;
              rsp_deci <= cache_deci;
              rsp_err  <= 1'b0;
            end
`endif
          end
        end
        ST_START: wait_cnt <= '0;
        ST_WAIT: begin
          if (eng_done) begin
            rsp_int  <= eng_int;
            rsp_deci <= eng_deci;
            rsp_err  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_int  <= '0;
            rsp_deci <= '0;
            rsp_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: rr_ptr <= wrap_idx(gnt_idx, 1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_req_sched.sv
`timescale 1ns/1ps
module tb_temp_req_sched;

  localparam int TO_CYC = 100;
  localparam int C_CYC  = 50;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [2:0] req;
  logic [2:0] ack;
  logic [7:0] rsp_int, rsp_deci;
  logic       rsp_err, eng_start, eng_done, busy;
  logic [7:0] eng_int, eng_deci;

  always #10 sys_clk = ~sys_clk;

  temp_req_sched #(.NUM_REQ(3), .TIMEOUT_CYC(TO_CYC), .CACHE_CYC(C_CYC)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req       (req),
    .ack       (ack),
    .rsp_int   (rsp_int),
    .rsp_deci  (rsp_deci),
    .rsp_err   (rsp_err),
    .eng_start (eng_start),
    .eng_done  (eng_done),
    .eng_int   (eng_int),
    .eng_deci  (eng_deci),
    .busy      (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- engine model ----------------
  int         eng_delay   = 20;   // 0 = silent engine
  logic [7:0] eng_val_int = 8'd25;
  logic [7:0] eng_val_dec = 8'd3;
  int         eng_gen     = 0;
  int         dlv_gen     = -1;
  logic [7:0] dlv_int, dlv_deci;

  initial begin
    eng_done = 1'b0;
    eng_int  = 8'd0;
    eng_deci = 8'd0;
    forever begin
      @(posedge sys_clk);
      if (eng_start === 1'b1 && sys_rst === 1'b0) begin
        int g;
        eng_gen++;
        g = eng_gen;
        if (eng_delay != 0) begin
          repeat (eng_delay - 1) @(posedge sys_clk);
          #1;
          eng_done = 1'b1;
          eng_int  = eng_val_int;
          eng_deci = eng_val_dec;
          dlv_gen  = g;
          dlv_int  = eng_val_int;
          dlv_deci = eng_val_dec;
          @(posedge sys_clk);
          #1;
          eng_done = 1'b0;
          eng_int  = 8'd0;
          eng_deci = 8'd0;
        end
      end
    end
  end

  // ---------------- behavioural scheduler model ----------------
  int         cyc     = 0;
  int         m_ptr   = 0;
  int         m_gnt   = 0;
  int         st_gen  = 0;
  int         r_cyc   = 0;
  int         n_start = 0;
  int         n_ack   = 0;
  bit         m_pend  = 0;
  bit         m_cvld  = 0;
  bit         prev_ack = 0;
  logic [7:0] m_cint = 0, m_cdeci = 0;
  logic [2:0] req_prev = 3'b000;

  always @(posedge sys_clk) cyc++;

  function automatic int pick(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++) if (r[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  // Cache freshness for a grant whose START/RESP cycle is t (sampled in t-1).
  function automatic bit fresh(input int t);
`ifdef TEMP_SCHED_CACHE_EN
    return m_cvld && ((t - 1 - r_cyc) < C_CYC);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge sys_clk) begin
    logic [7:0] e_int, e_deci;
    bit         e_err, from_eng;
    if (sys_rst === 1'b1) begin
      m_ptr = 0; m_pend = 0; m_cvld = 0; prev_ack = 0;
    end else begin
      if (eng_start === 1'b1) begin
        n_start++;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_while_pending", 32'(m_pend), 32'd0);
        chk("start_on_fresh_cache", 32'(fresh(cyc)), 32'd0);
        m_gnt = pick(req_prev, m_ptr);
        chk("start_without_req", 32'(m_gnt >= 0), 32'd1);
        if (m_gnt < 0) m_gnt = 0;
        m_pend = 1;
        st_gen++;
      end
      if (ack !== 3'b000) begin
        n_ack++;
        chk("ack_back_to_back", 32'(prev_ack), 32'd0);
        chk("ack_busy", 32'(busy), 32'd1);
        from_eng = m_pend;
        if (!m_pend) begin
          chk("ack_hit_fresh", 32'(fresh(cyc)), 32'd1);
          m_gnt = pick(req_prev, m_ptr);
          if (m_gnt < 0) m_gnt = 0;
          e_err = 0; e_int = m_cint; e_deci = m_cdeci;
        end else if (dlv_gen == st_gen) begin
          e_err = 0; e_int = dlv_int; e_deci = dlv_deci;
        end else begin
          e_err = 1; e_int = 8'd0; e_deci = 8'd0;
        end
        chk("model_ack", 32'(ack), 32'(3'b001 << m_gnt));
        chk("model_rsp_int", 32'(rsp_int), 32'(e_int));
        chk("model_rsp_deci", 32'(rsp_deci), 32'(e_deci));
        chk("model_rsp_err", 32'(rsp_err), 32'(e_err));
        if (from_eng) begin
          if (e_err) m_cvld = 0;
          else begin
            m_cvld = 1; m_cint = e_int; m_cdeci = e_deci; r_cyc = cyc;
          end
        end
        m_ptr  = (m_gnt + 1) % 3;
        m_pend = 0;
      end
      prev_ack = (ack !== 3'b000);
    end
    req_prev = req;
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ack(input int limit, output int lat, output logic [2:0] a,
                          output logic [7:0] ri, output logic [7:0] rd, output logic re);
    lat = 0; a = 3'b000; ri = 8'd0; rd = 8'd0; re = 1'b0;
    while (lat < limit) begin
      @(posedge sys_clk);
      lat++;
      @(negedge sys_clk);
      if (ack !== 3'b000) begin
        a = ack; ri = rsp_int; rd = rsp_deci; re = rsp_err;
        break;
      end
    end
    if (a === 3'b000) begin
      n_chk++; n_fail++;
      $display("FAIL ack_wait: no ack within %0d cycles", limit);
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic serve(input string name, input logic [2:0] r, input logic [2:0] r_after,
                       input logic [2:0] e_ack, input int e_lat, input int e_int,
                       input int e_deci, input int e_err, input int e_starts);
    int         lat, s0;
    logic [2:0] a;
    logic [7:0] ri, rd;
    logic       re;
    s0  = n_start;
    req = r;
    wait_ack(300, lat, a, ri, rd, re);
    req = r_after;
    chk({name, "_ack"}, 32'(a), 32'(e_ack));
    chk({name, "_latency"}, 32'(lat), 32'(e_lat));
    chk({name, "_int"}, 32'(ri), 32'(e_int));
    chk({name, "_deci"}, 32'(rd), 32'(e_deci));
    chk({name, "_err"}, 32'(re), 32'(e_err));
    chk({name, "_starts"}, 32'(n_start - s0), 32'(e_starts));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_start();
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge sys_clk);
      if (eng_start === 1'b1) break;
    end
    if (k == 20) begin
      n_chk++; n_fail++;
      $display("FAIL start_wait: no eng_start within 20 cycles");
    end
  endtask

  initial begin
    int         a0, lat;
    logic [2:0] a;
    logic [7:0] ri, rd;
    logic       re;

    sys_rst = 1'b1;
    req     = 3'b000;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_rsp", 32'({rsp_int, rsp_deci, 7'd0, rsp_err}), 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    idle(2);

`ifndef TEMP_SCHED_CACHE_EN
    // Round robin with all three requests held.
    serve("rr1", 3'b111, 3'b111, 3'b001, 22, 25, 3, 0, 1);
    serve("rr2", 3'b111, 3'b111, 3'b010, 22, 25, 3, 0, 1);
    serve("rr3", 3'b111, 3'b111, 3'b100, 22, 25, 3, 0, 1);
    serve("rr4", 3'b111, 3'b000, 3'b001, 22, 25, 3, 0, 1);
    idle(5);
`endif

    serve("single", 3'b001, 3'b000, 3'b001, 22, 25, 3, 0, 1);

`ifdef TEMP_SCHED_CACHE_EN
    idle(20);
    serve("cache_hit", 3'b010, 3'b000, 3'b010, 1, 25, 3, 0, 0);
    idle(40);
    serve("cache_stale", 3'b010, 3'b000, 3'b010, 22, 25, 3, 0, 1);
`endif

    // Silent engine: timeout answer, then engine restarts normally.
    idle(60);
    eng_delay = 0;
    serve("timeout", 3'b100, 3'b000, 3'b100, 102, 0, 0, 1, 1);
    eng_delay = 20;
    idle(3);
    serve("after_timeout", 3'b001, 3'b000, 3'b001, 22, 25, 3, 0, 1);

    // eng_done on the final WAIT cycle beats the timeout.
    idle(60);
    eng_delay = 100; eng_val_int = 8'd30; eng_val_dec = 8'd7;
    serve("done_at_timeout", 3'b010, 3'b000, 3'b010, 102, 30, 7, 0, 1);
    eng_delay = 20; eng_val_int = 8'd25; eng_val_dec = 8'd3;

    // Reset in the 10th WAIT cycle.
    idle(60);
    req = 3'b010;
    wait_start();
    @(posedge sys_clk);
    repeat (9) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    req     = 3'b000;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    chk("rstwait_busy", 32'(busy), 32'd0);
    chk("rstwait_ack", 32'(ack), 32'd0);
    chk("rstwait_rsp_int", 32'(rsp_int), 32'd0);
    chk("rstwait_rsp_deci", 32'(rsp_deci), 32'd0);
    a0 = n_ack;
    idle(30);
    chk("rstwait_late_done_ignored", 32'(n_ack - a0), 32'd0);
    chk("rstwait_idle_busy", 32'(busy), 32'd0);
    serve("rstwait_ptr0", 3'b111, 3'b000, 3'b001, 22, 25, 3, 0, 1);

    // Request dropped after grant still gets its ack.
    idle(60);
    req = 3'b100;
    wait_start();
    @(posedge sys_clk);
    #1;
    req = 3'b000;
    wait_ack(100, lat, a, ri, rd, re);
    chk("drop_ack", 32'(a), 32'(3'b100));
    chk("drop_int", 32'(ri), 32'd25);

    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
